lc4_mmio_responder: RTL and testbench
=====================================

// Module: lc4_mmio_responder
// PURPOSE
//  Responder side of the LC4 data-memory port. Addresses below IO_BASE pass through to data RAM;
//  IO_BASE..16'hFFFF hit device registers:
//  - switch-event (KBSR/KBDR)
//  - LED output register
//  - interval timer (TMSR/TMIR)
//  Sits between the core's dmem port and the RAM; gwe-qualified so single-step clocking stays exact.
// PARAMETERS
//  IO_BASE    16'hFE00  first device address; all addresses >= IO_BASE are I/O, never RAM
//  SYNC_DEPTH 2         flops in the switch synchronizer (>=2)
// PORTS
//  clk          in   1   single clock
//  rst          in   1   reset, asynchronous, active-high
//  gwe          in   1   global write enable; no state changes on edges where gwe=0
//  i_addr       in   16  core data address
//  i_we         in   1   core store strobe
//  i_wdata      in   16  core store data
//  o_rdata      out  16  read data to core, combinational
//  o_ram_we     out  1   RAM write enable (i_we & RAM-region)
//  i_ram_rdata  in   16  RAM read data, combinational
//  switch_data  in   8   raw board switches, asynchronous
//  led_data     out  8   LED register contents
//  o_timer_irq  out  1   mirror of TMSR[15]
// BEHAVIOUR
//  Register map, offsets from IO_BASE; unlisted I/O addresses read 0, writes ignored.
//  - +0 KBSR (R): [15] ready, [14] overrun, rest 0
//  - +2 KBDR (R): {8'h00, captured switches}
//  - +4 LEDR (R/W): low 8 bits stored, reads {8'h00, led}
//  - +8 TMSR (R): [15] expired
//  - +A TMIR (R/W): 16-bit interval in gwe-cycles; 0 = timer off
//  Reads are combinational, zero latency: o_rdata = RAM region ? i_ram_rdata : device mux.
//  "Access" = a clk edge with gwe=1 and i_addr matching. Read side effects apply only on an access
//  with i_we=0.
//  Reset (async, immediate): all registers and counter 0, sync chain 0, led_data=0, o_timer_irq=0.
//  Post-reset baseline = first synchronized switch value; no event is raised for it.
//  Switch event, sub-module:
//  - synced value != baseline -> baseline<=synced, KBDR<=synced, KBSR[15]<=1
//  - if KBSR[15] already 1 -> KBSR[14]<=1
//  - KBDR read -> KBSR[15:14]<=0
//  - event and KBDR read on same edge -> event wins: ready=1, overrun=0, data=new
//  Timer, counter advances only on gwe=1 edges:
//  - TMIR!=0: count==TMIR-1 -> count<=0, TMSR[15]<=1; else count+1
//  - TMSR read clears [15]
//  - expiry and TMSR read on same edge -> stays 1
//  - TMIR write -> TMIR<=wdata, count<=0, TMSR unchanged
//  - TMIR=1 -> expiry every gwe cycle
//  - count is 16-bit and never exceeds TMIR-1
//  Stores to read-only registers ignored. o_ram_we=0 for every I/O address. No wrap: FFFF is I/O.
// STRUCTURE
//  Package lc4_mmio_pkg:
//  - register offsets
//  - KBSR_READY=15, KBSR_OVR=14, TMSR_EXP=15
//  - IO_BASE default
//  Sub-module lc4_switch_event: synchronizer + baseline compare + KBSR/KBDR state.
//  Timer, LEDR and decode stay in the top level.
// TESTING
//  - rst mid-run (TMIR=5, LED=0xA5) -> led_data=0, o_rdata(FE0A)=0 immediately, before any clk edge.
//  - switch 00->3C, then KBDR read -> after SYNC_DEPTH+1 edges KBSR=8000, KBDR=003C; after read KBSR=0000.
//  - two changes (3C, then 81) without a read -> KBSR=C000, KBDR=0081; change coincident with a KBDR
//    read -> KBSR=8000.
//  - store 1234 to FE04, then store to 7FFF with value 0055 -> led_data=34, FE04 reads 0034;
//    o_ram_we=1 only for the 7FFF store.
//  - TMIR=3, gwe held 1 -> TMSR=8000 on the 3rd edge; read clears; re-sets 3 edges later; gwe=0 freezes count.
//  - read of FE06 and FFFE -> 0000, o_ram_we=0, i_ram_rdata ignored.

Source files
------------

// File: rtl/lc4_mmio_pkg.sv
// Shared constants for the LC4 memory-mapped I/O responder: register offsets,
// status bit positions and the device-select decode.
package lc4_mmio_pkg;

  localparam logic [15:0] IO_BASE_DEFAULT = 16'hFE00;

  localparam logic [15:0] OFF_KBSR = 16'h0000;
  localparam logic [15:0] OFF_KBDR = 16'h0002;
  localparam logic [15:0] OFF_LEDR = 16'h0004;
  localparam logic [15:0] OFF_TMSR = 16'h0008;
  localparam logic [15:0] OFF_TMIR = 16'h000A;

  localparam int KBSR_READY = 15;
  localparam int KBSR_OVR   = 14;
  localparam int TMSR_EXP   = 15;

  typedef enum logic [2:0] {
    DEV_NONE = 3'd0,
    DEV_KBSR = 3'd1,
    DEV_KBDR = 3'd2,
    DEV_LEDR = 3'd3,
    DEV_TMSR = 3'd4,
    DEV_TMIR = 3'd5
  } dev_sel_e;

  function automatic dev_sel_e decode_dev(input logic [15:0] off);
    dev_sel_e sel;
    case (off)
      OFF_KBSR: sel = DEV_KBSR;
      OFF_KBDR: sel = DEV_KBDR;
      OFF_LEDR: sel = DEV_LEDR;
      OFF_TMSR: sel = DEV_TMSR;
      OFF_TMIR: sel = DEV_TMIR;
      default:  sel = DEV_NONE;
    endcase
    return sel;
  endfunction

endpackage

// File: rtl/lc4_switch_event.sv
// Switch-event device: synchronizes the raw board switches, compares against a
// baseline and keeps the KBSR ready/overrun flags and the KBDR capture.
module lc4_switch_event
  import lc4_mmio_pkg::*;
#(
  parameter int SYNC_DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        gwe,
  input  logic [7:0]  switch_data,
  input  logic        i_kbdr_rd,
  output logic [15:0] o_kbsr,
  output logic [15:0] o_kbdr
);

  localparam int FILL_W = $clog2(SYNC_DEPTH + 1);

  logic [7:0]        r_sync [SYNC_DEPTH];
  logic [FILL_W-1:0] r_fill;
  logic              r_base_ok;
  logic [7:0]        r_base;
  logic [7:0]        r_kbdr;
  logic              r_ready;
  logic              r_ovr;

  logic [7:0] w_synced;
  logic       w_primed;
  logic       w_event;

  // r_fill counts real samples in the chain so the reset zeros are never taken as the baseline
  assign w_synced = r_sync[SYNC_DEPTH-1];
  assign w_primed = (r_fill == FILL_W'(SYNC_DEPTH));
  assign w_event  = w_primed && r_base_ok && (w_synced != r_base);

  // synchronizer chain and priming counter
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < SYNC_DEPTH; i++) begin
        r_sync[i] <= 8'h00;
      end
      r_fill <= '0;
    end else if (gwe) begin
      r_sync[0] <= switch_data;
      for (int i = 1; i < SYNC_DEPTH; i++) begin
        r_sync[i] <= r_sync[i-1];
      end
      if (!w_primed) begin
        r_fill <= r_fill + FILL_W'(1);
      end
    end
  end

  // baseline, capture and status flags; an event beats a same-edge KBDR read
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_base_ok <= 1'b0;
      r_base    <= 8'h00;
      r_kbdr    <= 8'h00;
      r_ready   <= 1'b0;
      r_ovr     <= 1'b0;
    end else if (gwe) begin
      if (w_primed && !r_base_ok) begin
        r_base    <= w_synced;
        r_base_ok <= 1'b1;
      end
      if (w_event) begin
        r_base  <= w_synced;
        r_kbdr  <= w_synced;
        r_ready <= 1'b1;
        r_ovr   <= i_kbdr_rd ? 1'b0 : (r_ovr | r_ready);
      end else if (i_kbdr_rd) begin
        r_ready <= 1'b0;
        r_ovr   <= 1'b0;
      end
    end
  end

  always_comb begin
    o_kbsr             = 16'h0000;
    o_kbsr[KBSR_READY] = r_ready;
    o_kbsr[KBSR_OVR]   = r_ovr;
  end

  assign o_kbdr = {8'h00, r_kbdr};

endmodule

// File: rtl/lc4_mmio_responder.sv
// LC4 data-memory responder: passes RAM traffic through below IO_BASE and
// serves the switch, LED and interval-timer registers above it.
module lc4_mmio_responder
  import lc4_mmio_pkg::*;
#(
  parameter logic [15:0] IO_BASE    = IO_BASE_DEFAULT,
  parameter int          SYNC_DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        gwe,
  input  logic [15:0] i_addr,
  input  logic        i_we,
  input  logic [15:0] i_wdata,
  output logic [15:0] o_rdata,
  output logic        o_ram_we,
  input  logic [15:0] i_ram_rdata,
  input  logic [7:0]  switch_data,
  output logic [7:0]  led_data,
  output logic        o_timer_irq
);

  logic      w_is_io;
  logic [15:0] w_off;
  dev_sel_e  w_sel;
  logic      w_kbdr_rd;
  logic      w_tmsr_rd;
  logic      w_led_wr;
  logic      w_tmir_wr;
  logic      w_expire;
  logic [15:0] w_kbsr;
  logic [15:0] w_kbdr;
  logic [15:0] w_tmsr;
  logic [15:0] w_dev_rdata;

  logic [7:0]  r_led;
  logic [15:0] r_tmir;
  logic [15:0] r_count;
  logic        r_tmsr_exp;

  // the I/O window runs to 16'hFFFF with no wrap back into RAM
  assign w_is_io = (i_addr >= IO_BASE);
  assign w_off   = i_addr - IO_BASE;
  assign w_sel   = w_is_io ? decode_dev(w_off) : DEV_NONE;

  assign w_kbdr_rd = gwe & ~i_we & (w_sel == DEV_KBDR);
  assign w_tmsr_rd = gwe & ~i_we & (w_sel == DEV_TMSR);
  assign w_led_wr  = gwe &  i_we & (w_sel == DEV_LEDR);
  assign w_tmir_wr = gwe &  i_we & (w_sel == DEV_TMIR);

  assign o_ram_we = i_we & ~w_is_io;

  lc4_switch_event #(
    .SYNC_DEPTH (SYNC_DEPTH)
  ) u_switch_event (
    .clk         (clk),
    .rst         (rst),
    .gwe         (gwe),
    .switch_data (switch_data),
    .i_kbdr_rd   (w_kbdr_rd),
    .o_kbsr      (w_kbsr),
    .o_kbdr      (w_kbdr)
  );

  // LED output register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_led <= 8'h00;
    end else if (w_led_wr) begin
      r_led <= i_wdata[7:0];
    end
  end

  assign w_expire = (r_tmir != 16'h0000) && (r_count == (r_tmir - 16'h0001));

  // interval timer: a TMIR write restarts the count but leaves TMSR alone
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_tmir     <= 16'h0000;
      r_count    <= 16'h0000;
      r_tmsr_exp <= 1'b0;
    end else if (gwe) begin
      if (w_tmir_wr) begin
        r_tmir  <= i_wdata;
        r_count <= 16'h0000;
      end else if (r_tmir != 16'h0000) begin
        r_count <= w_expire ? 16'h0000 : (r_count + 16'h0001);
      end
      if (w_expire && !w_tmir_wr) begin
        r_tmsr_exp <= 1'b1;
      end else if (w_tmsr_rd) begin
        r_tmsr_exp <= 1'b0;
      end
    end
  end

  always_comb begin
    w_tmsr           = 16'h0000;
    w_tmsr[TMSR_EXP] = r_tmsr_exp;
  end

  // device read mux; unmapped I/O addresses read zero
  always_comb begin
    w_dev_rdata = 16'h0000;
    case (w_sel)
      DEV_KBSR: w_dev_rdata = w_kbsr;
      DEV_KBDR: w_dev_rdata = w_kbdr;
      DEV_LEDR: w_dev_rdata = {8'h00, r_led};
      DEV_TMSR: w_dev_rdata = w_tmsr;
      DEV_TMIR: w_dev_rdata = r_tmir;
      default:  w_dev_rdata = 16'h0000;
    endcase
  end

  assign o_rdata     = w_is_io ? w_dev_rdata : i_ram_rdata;
  assign led_data    = r_led;
  assign o_timer_irq = r_tmsr_exp;

endmodule

// File: tb/tb_lc4_mmio_responder.sv
// Randomized self-checking bench for lc4_mmio_responder against a register-map
// level reference model (switch history queue, tick-count timer).
module tb_lc4_mmio_responder;

  localparam int          SD  = 2;
  localparam logic [15:0] IOB = 16'hFE00;

  logic        clk = 1'b0;
  logic        rst;
  logic        gwe;
  logic [15:0] i_addr;
  logic        i_we;
  logic [15:0] i_wdata;
  logic [15:0] o_rdata;
  logic        o_ram_we;
  logic [15:0] i_ram_rdata;
  logic [7:0]  switch_data;
  logic [7:0]  led_data;
  logic        o_timer_irq;

  int n_vec = 0;
  int n_bad = 0;

  // reference model state
  logic [7:0]  m_led;
  logic [15:0] m_tmir;
  int          m_ticks;
  logic        m_exp;
  logic        m_ready;
  logic        m_ovr;
  logic [7:0]  m_kbdr;
  logic [7:0]  m_base;
  logic        m_base_ok;
  logic [7:0]  sw_hist [$];

  always #5 clk = ~clk;

  lc4_mmio_responder #(
    .IO_BASE    (IOB),
    .SYNC_DEPTH (SD)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .gwe         (gwe),
    .i_addr      (i_addr),
    .i_we        (i_we),
    .i_wdata     (i_wdata),
    .o_rdata     (o_rdata),
    .o_ram_we    (o_ram_we),
    .i_ram_rdata (i_ram_rdata),
    .switch_data (switch_data),
    .led_data    (led_data),
    .o_timer_irq (o_timer_irq)
  );

  task automatic model_reset();
    m_led = 8'h00; m_tmir = 16'h0000; m_ticks = 0; m_exp = 1'b0;
    m_ready = 1'b0; m_ovr = 1'b0; m_kbdr = 8'h00; m_base = 8'h00; m_base_ok = 1'b0;
    sw_hist.delete();
  endtask

  // A switch value is seen SD gwe-edges after it was sampled; the first seen value is the baseline.
  task automatic model_edge();
    logic        io;
    logic [15:0] off;
    logic [7:0]  seen;
    logic        ev;
    logic        kb_rd;
    if (!gwe) return;
    io    = (i_addr >= IOB);
    off   = i_addr - IOB;
    kb_rd = io && (off == 16'h0002) && !i_we;
    sw_hist.push_back(switch_data);
    if (sw_hist.size() > SD + 1) void'(sw_hist.pop_front());
    ev = 1'b0; seen = 8'h00;
    if (sw_hist.size() == SD + 1) begin
      seen = sw_hist[0];
      if (!m_base_ok) begin m_base = seen; m_base_ok = 1'b1; end
      else ev = (seen != m_base);
    end
    if (ev) begin
      m_ovr = kb_rd ? 1'b0 : (m_ovr | m_ready);
      m_ready = 1'b1; m_kbdr = seen; m_base = seen;
    end else if (kb_rd) begin
      m_ready = 1'b0; m_ovr = 1'b0;
    end
    if (io && off == 16'h0004 && i_we) m_led = i_wdata[7:0];
    if (io && off == 16'h000A && i_we) begin
      m_tmir = i_wdata; m_ticks = 0;
    end else begin
      ev = 1'b0;
      if (m_tmir != 16'h0000) begin
        m_ticks++;
        ev = ((m_ticks % int'(m_tmir)) == 0);
      end
      if (ev) m_exp = 1'b1;
      else if (io && off == 16'h0008 && !i_we) m_exp = 1'b0;
    end
  endtask

  function automatic logic [15:0] exp_rdata(input logic [15:0] a, input logic [15:0] ram);
    if (a < IOB) return ram;
    case (a - IOB)
      16'h0000: return {m_ready, m_ovr, 14'h0000};
      16'h0002: return {8'h00, m_kbdr};
      16'h0004: return {8'h00, m_led};
      16'h0008: return {m_exp, 15'h0000};
      16'h000A: return m_tmir;
      default:  return 16'h0000;
    endcase
  endfunction

  task automatic drive(input logic [15:0] a, input logic w, input logic [15:0] d);
    i_addr = a; i_we = w; i_wdata = d;
    #1;
  endtask

  task automatic tick();
    model_edge();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    logic [15:0] regs [5] = '{16'hFE00, 16'hFE02, 16'hFE04, 16'hFE08, 16'hFE0A};
    rst = 1'b1; gwe = 1'b1; switch_data = 8'h00; i_ram_rdata = 16'hBEEF;
    drive(16'h0100, 1'b0, 16'h0000);
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    n_vec++; if (led_data !== 8'h00) begin n_bad++; $display("FAIL reset_led got %h want 00", led_data); end
    n_vec++; if (o_timer_irq !== 1'b0) begin n_bad++; $display("FAIL reset_irq got %b want 0", o_timer_irq); end
    foreach (regs[i]) begin
      drive(regs[i], 1'b0, 16'h0000);
      n_vec++; if (o_rdata !== 16'h0000) begin n_bad++; $display("FAIL reset_reg addr=%h got %h want 0000", regs[i], o_rdata); end
    end
    rst = 1'b0;
    drive(16'h0100, 1'b0, 16'h0000);
    repeat (SD + 3) tick();
    drive(16'hFE00, 1'b0, 16'h0000);
    n_vec++; if (o_rdata !== 16'h0000) begin n_bad++; $display("FAIL baseline_no_event got %h want 0000", o_rdata); end
  endtask

  task automatic test_led_ram();
    logic [15:0] v;
    drive(16'hFE04, 1'b1, 16'h1234);
    n_vec++; if (o_ram_we !== 1'b0) begin n_bad++; $display("FAIL led_store_ramwe got %b want 0", o_ram_we); end
    tick();
    n_vec++; if (led_data !== 8'h34) begin n_bad++; $display("FAIL led_store got %h want 34", led_data); end
    drive(16'h7FFF, 1'b1, 16'h0055);
    n_vec++; if (o_ram_we !== 1'b1) begin n_bad++; $display("FAIL ram_store_we got %b want 1", o_ram_we); end
    tick();
    n_vec++; if (led_data !== 8'h34) begin n_bad++; $display("FAIL ram_store_led got %h want 34", led_data); end
    drive(16'hFE04, 1'b0, 16'h0000);
    n_vec++; if (o_rdata !== 16'h0034) begin n_bad++; $display("FAIL led_read got %h want 0034", o_rdata); end
    i_ram_rdata = 16'(($urandom));
    drive(16'h7FFF, 1'b0, 16'h0000);
    n_vec++; if (o_rdata !== i_ram_rdata) begin n_bad++; $display("FAIL ram_read got %h want %h", o_rdata, i_ram_rdata); end
    for (int k = 0; k < 8; k++) begin
      v = 16'($urandom);
      drive(16'hFE04, 1'b1, v);
      tick();
      n_vec++; if (led_data !== m_led) begin n_bad++; $display("FAIL led_rand got %h want %h", led_data, m_led); end
    end
  endtask

  task automatic test_switch_event();
    logic [15:0] a;
    switch_data = 8'h3C;
    drive(16'hFE00, 1'b0, 16'h0000);
    repeat (SD) tick();
    n_vec++; if (o_rdata !== 16'h0000) begin n_bad++; $display("FAIL sw_early got %h want 0000", o_rdata); end
    tick();
    n_vec++; if (o_rdata !== 16'h8000) begin n_bad++; $display("FAIL sw_ready got %h want 8000", o_rdata); end
    drive(16'hFE02, 1'b0, 16'h0000);
    n_vec++; if (o_rdata !== 16'h003C) begin n_bad++; $display("FAIL sw_kbdr got %h want 003C", o_rdata); end
    tick();
    drive(16'hFE00, 1'b0, 16'h0000);
    n_vec++; if (o_rdata !== 16'h0000) begin n_bad++; $display("FAIL sw_read_clear got %h want 0000", o_rdata); end
    switch_data = 8'h5A;
    repeat (SD + 1) tick();
    switch_data = 8'h81;
    repeat (SD + 1) tick();
    n_vec++; if (o_rdata !== 16'hC000) begin n_bad++; $display("FAIL sw_overrun got %h want C000", o_rdata); end
    drive(16'hFE02, 1'b0, 16'h0000);
    n_vec++; if (o_rdata !== 16'h0081) begin n_bad++; $display("FAIL sw_overrun_data got %h want 0081", o_rdata); end
    tick();
    switch_data = 8'h42;
    drive(16'hFE00, 1'b0, 16'h0000);
    repeat (SD) tick();
    drive(16'hFE02, 1'b0, 16'h0000);
    tick();
    drive(16'hFE00, 1'b0, 16'h0000);
    n_vec++; if (o_rdata !== 16'h8000) begin n_bad++; $display("FAIL sw_coincident got %h want 8000", o_rdata); end
    drive(16'hFE02, 1'b0, 16'h0000);
    n_vec++; if (o_rdata !== 16'h0042) begin n_bad++; $display("FAIL sw_coincident_data got %h want 0042", o_rdata); end
    for (int k = 0; k < 60; k++) begin
      if ($urandom_range(0, 1) == 0) switch_data = 8'($urandom);
      gwe = ($urandom_range(0, 3) != 0);
      case ($urandom_range(0, 2))
        0:       a = 16'hFE00;
        1:       a = 16'hFE02;
        default: a = 16'h1234;
      endcase
      i_ram_rdata = 16'($urandom);
      drive(a, 1'b0, 16'h0000);
      n_vec++; if (o_rdata !== exp_rdata(a, i_ram_rdata)) begin n_bad++; $display("FAIL sw_rand addr=%h got %h want %h", a, o_rdata, exp_rdata(a, i_ram_rdata)); end
      tick();
    end
    gwe = 1'b1;
  endtask

  task automatic test_timer();
    logic [15:0] tv [5] = '{16'd0, 16'd1, 16'd2, 16'd3, 16'd5};
    drive(16'hFE0A, 1'b1, 16'd3);
    tick();
    drive(16'h0300, 1'b0, 16'h0000);
    for (int i = 1; i <= 3; i++) begin
      tick();
      n_vec++; if (o_timer_irq !== (i == 3)) begin n_bad++; $display("FAIL tmr_expire edge=%0d got %b want %b", i, o_timer_irq, (i == 3)); end
    end
    drive(16'hFE08, 1'b0, 16'h0000);
    n_vec++; if (o_rdata !== 16'h8000) begin n_bad++; $display("FAIL tmsr_read got %h want 8000", o_rdata); end
    tick();
    n_vec++; if (o_timer_irq !== 1'b0) begin n_bad++; $display("FAIL tmsr_clear got %b want 0", o_timer_irq); end
    drive(16'h0300, 1'b0, 16'h0000);
    tick();
    gwe = 1'b0;
    repeat (5) tick();
    n_vec++; if (o_timer_irq !== 1'b0) begin n_bad++; $display("FAIL tmr_frozen got %b want 0", o_timer_irq); end
    gwe = 1'b1;
    tick();
    n_vec++; if (o_timer_irq !== 1'b1) begin n_bad++; $display("FAIL tmr_reexpire got %b want 1", o_timer_irq); end
    drive(16'hFE08, 1'b0, 16'h0000);
    tick();
    drive(16'hFE0A, 1'b1, 16'd1);
    tick();
    n_vec++; if (o_timer_irq !== 1'b0) begin n_bad++; $display("FAIL tmir_write_keeps got %b want 0", o_timer_irq); end
    drive(16'hFE08, 1'b0, 16'h0000);
    for (int i = 0; i < 4; i++) begin
      tick();
      n_vec++; if (o_timer_irq !== 1'b1 || o_rdata !== 16'h8000) begin n_bad++; $display("FAIL tmr_every_cycle irq=%b rdata=%h want 1/8000", o_timer_irq, o_rdata); end
    end
    for (int k = 0; k < 60; k++) begin
      gwe = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 9) == 0) drive(16'hFE0A, 1'b1, tv[$urandom_range(0, 4)]);
      else if ($urandom_range(0, 2) == 0) drive(16'hFE08, 1'b0, 16'h0000);
      else drive(16'hFE0A, 1'b0, 16'h0000);
      if (!i_we) begin
        n_vec++; if (o_rdata !== exp_rdata(i_addr, i_ram_rdata)) begin n_bad++; $display("FAIL tmr_rand_rd addr=%h got %h want %h", i_addr, o_rdata, exp_rdata(i_addr, i_ram_rdata)); end
      end
      tick();
      n_vec++; if (o_timer_irq !== m_exp) begin n_bad++; $display("FAIL tmr_rand_irq got %b want %b", o_timer_irq, m_exp); end
    end
    gwe = 1'b1;
  endtask

  task automatic test_unmapped();
    logic [15:0] ua [6] = '{16'hFE06, 16'hFFFE, 16'hFFFF, 16'hFE01, 16'hFE00, 16'hFE08};
    foreach (ua[i]) begin
      i_ram_rdata = 16'($urandom);
      drive(ua[i], 1'b0, 16'h0000);
      if (i < 4) begin
        n_vec++; if (o_rdata !== 16'h0000) begin n_bad++; $display("FAIL unmapped_read addr=%h got %h want 0000", ua[i], o_rdata); end
      end
      drive(ua[i], 1'b1, 16'($urandom));
      n_vec++; if (o_ram_we !== 1'b0) begin n_bad++; $display("FAIL io_ramwe addr=%h got %b want 0", ua[i], o_ram_we); end
      tick();
    end
    drive(16'hFE04, 1'b0, 16'h0000);
    n_vec++; if (o_rdata !== {8'h00, m_led}) begin n_bad++; $display("FAIL unmapped_led got %h want %h", o_rdata, {8'h00, m_led}); end
    drive(16'hFE0A, 1'b0, 16'h0000);
    n_vec++; if (o_rdata !== m_tmir) begin n_bad++; $display("FAIL unmapped_tmir got %h want %h", o_rdata, m_tmir); end
    drive(16'hFE00, 1'b0, 16'h0000);
    n_vec++; if (o_rdata !== exp_rdata(16'hFE00, 16'h0000)) begin n_bad++; $display("FAIL ro_kbsr got %h want %h", o_rdata, exp_rdata(16'hFE00, 16'h0000)); end
  endtask

  task automatic test_reset_midrun();
    drive(16'hFE0A, 1'b1, 16'd5);
    tick();
    drive(16'hFE04, 1'b1, 16'h00A5);
    tick();
    n_vec++; if (led_data !== 8'hA5) begin n_bad++; $display("FAIL mid_led got %h want A5", led_data); end
    drive(16'hFE0A, 1'b0, 16'h0000);
    n_vec++; if (o_rdata !== 16'h0005) begin n_bad++; $display("FAIL mid_tmir got %h want 0005", o_rdata); end
    rst = 1'b1;
    #1;
    n_vec++; if (led_data !== 8'h00) begin n_bad++; $display("FAIL async_rst_led got %h want 00", led_data); end
    n_vec++; if (o_rdata !== 16'h0000) begin n_bad++; $display("FAIL async_rst_tmir got %h want 0000", o_rdata); end
    n_vec++; if (o_timer_irq !== 1'b0) begin n_bad++; $display("FAIL async_rst_irq got %b want 0", o_timer_irq); end
    model_reset();
    @(posedge clk);
    #1;
    rst = 1'b0;
    switch_data = 8'h77;
    drive(16'hFE00, 1'b0, 16'h0000);
    repeat (SD + 3) tick();
    n_vec++; if (o_rdata !== 16'h0000) begin n_bad++; $display("FAIL rebaseline got %h want 0000", o_rdata); end
  endtask

  initial begin
    test_reset();
    test_led_ram();
    test_switch_event();
    test_timer();
    test_unmapped();
    test_reset_midrun();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
